// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             alu_zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             alu_src;
    logic [3:0]       alu_sel;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             branch;
    logic             mem_err;
    logic             illegal_insn;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state_o;

    modport master (
        input  opcode, funct3, funct7_5, alu_zero, mem_ready,
        output pc_write, pc_src, ir_write, alu_src, alu_sel, mem_read, mem_write,
               mem_to_reg, reg_write, branch, mem_err, illegal_insn, instret, state_o
    );

    modport slave (
        output opcode, funct3, funct7_5, alu_zero, mem_ready,
        input  pc_write, pc_src, ir_write, alu_src, alu_sel, mem_read, mem_write,
               mem_to_reg, reg_write, branch, mem_err, illegal_insn, instret, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core with a bounded MEM wait.
// Optional macro ILLEGAL_TRAP_EN: unknown instructions trap into HALT instead of retiring as NOPs.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_LW  = 3'd2,
        C_SW  = 3'd3,
        C_BR  = 3'd4,
        C_UNK = 3'd5
    } cls_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    function automatic cls_t decode_cls(input logic [6:0] op, input logic [2:0] f3);
        cls_t c;
        case (op)
            7'b0110011: c = (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110) ? C_R : C_UNK;
            7'b0010011: c = (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110) ? C_I : C_UNK;
            7'b0000011: c = (f3 == 3'b010) ? C_LW : C_UNK;
            7'b0100011: c = (f3 == 3'b010) ? C_SW : C_UNK;
            7'b1100011: c = (f3 == 3'b000 || f3 == 3'b001) ? C_BR : C_UNK;
            default:    c = C_UNK;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] alu_func(input cls_t c, input logic [2:0] f3, input logic f7);
        logic [3:0] sel;
        case (f3)
            3'b111:  sel = ALU_AND;
            3'b110:  sel = ALU_OR;
            default: sel = (c == C_R && f7) ? ALU_SUB : ALU_ADD;
        endcase
        return sel;
    endfunction

    state_t     state_r, state_nxt;
    cls_t       cls_s;
    logic [7:0] tcnt_r, tcnt_nxt;
    logic [CNT_W-1:0] instret_r;
    logic       mem_err_r;
    logic       retire_s;
    logic       abort_s;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_r;
    logic       illegal_set_s;
`endif

    assign cls_s = decode_cls(bus.opcode, bus.funct3);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt;
        end
    end

    // MEM timeout counter, retire counter and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_r    <= 8'd0;
            instret_r <= {CNT_W{1'b0}};
            mem_err_r <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            tcnt_r    <= tcnt_nxt;
            mem_err_r <= mem_err_r | abort_s;
            if (retire_s) begin
                instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`ifdef ILLEGAL_TRAP_EN
            illegal_r <= illegal_r | illegal_set_s;
`endif
        end
    end

    // Next-state, retire and abort decision
    always_comb begin
        state_nxt = state_r;
        tcnt_nxt  = tcnt_r;
        retire_s  = 1'b0;
        abort_s   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_set_s = 1'b0;
`endif
        case (state_r)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                if (cls_s != C_UNK) begin
                    state_nxt = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_nxt     = S_HALT;
                    illegal_set_s = 1'b1;
`else
                    state_nxt = S_FETCH;
                    retire_s  = 1'b1;
`endif
                end
            end
            S_EXEC: begin
                case (cls_s)
                    C_R, C_I:   state_nxt = S_WB;
                    C_LW, C_SW: state_nxt = S_MEM;
                    C_BR: begin
                        state_nxt = S_FETCH;
                        retire_s  = 1'b1;
                    end
                    default:    state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                // A ready on the last allowed cycle still completes normally
                if (bus.mem_ready) begin
                    tcnt_nxt = 8'd0;
                    if (cls_s == C_LW) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_FETCH;
                        retire_s  = (cls_s == C_SW);
                    end
                end else if (tcnt_r == TMO_LAST) begin
                    tcnt_nxt  = 8'd0;
                    abort_s   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    tcnt_nxt = tcnt_r + 8'd1;
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire_s  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT:  state_nxt = S_HALT;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // Control-line decode of current state and IR fields; everything quiet in reset
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_sel    = ALU_ADD;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.branch     = 1'b0;
        if (rst_n) begin
            case (state_r)
                S_FETCH: begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end
                S_EXEC: begin
                    case (cls_s)
                        C_R: bus.alu_sel = alu_func(cls_s, bus.funct3, bus.funct7_5);
                        C_I: begin
                            bus.alu_sel = alu_func(cls_s, bus.funct3, bus.funct7_5);
                            bus.alu_src = 1'b1;
                        end
                        C_LW, C_SW: bus.alu_src = 1'b1;
                        C_BR: begin
                            bus.alu_sel  = ALU_SUB;
                            bus.branch   = 1'b1;
                            bus.pc_src   = 1'b1;
                            bus.pc_write = bus.funct3[0] ? ~bus.alu_zero : bus.alu_zero;
                        end
                        default: bus.alu_sel = ALU_ADD;
                    endcase
                end
                S_MEM: begin
                    bus.mem_read  = (cls_s == C_LW);
                    bus.mem_write = (cls_s == C_SW);
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (cls_s == C_LW);
                end
                default: bus.alu_sel = ALU_ADD;
            endcase
        end else begin
            bus.alu_sel = ALU_ADD;
        end
    end

    assign bus.state_o = state_r;
    assign bus.instret = instret_r;
    assign bus.mem_err = mem_err_r;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_insn = illegal_r;
`else
    assign bus.illegal_insn = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations come from an
// instruction-level model (cycle-count and control rules per instruction kind).
module tb_multicycle_ctrl;
    localparam int TMO   = 15;
    localparam int CNT_W = 32;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_ANDI, K_ORI,
                      K_LW, K_SW, K_BEQ, K_BNE, K_UNK} kind_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        pc_write;
        logic        pc_src;
        logic        ir_write;
        logic        alu_src;
        logic [3:0]  alu_sel;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic        branch;
        logic        mem_err;
        logic        ill;
        logic [31:0] instret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] instret_m;
    logic        mem_err_m;
    logic        ill_m;

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e         = '0;
        e.st      = st;
        e.alu_sel = A_ADD;
        e.mem_err = mem_err_m;
        e.ill     = ill_m;
        e.instret = instret_m;
        return e;
    endfunction

    function automatic kind_t kind_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (op == 7'b0110011) begin
            if (f3 == 3'b000) return f7 ? K_SUB : K_ADD;
            if (f3 == 3'b111) return K_AND;
            if (f3 == 3'b110) return K_OR;
            return K_UNK;
        end
        if (op == 7'b0010011) begin
            if (f3 == 3'b000) return K_ADDI;
            if (f3 == 3'b111) return K_ANDI;
            if (f3 == 3'b110) return K_ORI;
            return K_UNK;
        end
        if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
        if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
        if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
        if (op == 7'b1100011 && f3 == 3'b001) return K_BNE;
        return K_UNK;
    endfunction

    function automatic logic [3:0] alu_of(input kind_t k);
        case (k)
            K_SUB, K_BEQ, K_BNE: return A_SUB;
            K_AND, K_ANDI:       return A_AND;
            K_OR, K_ORI:         return A_OR;
            default:             return A_ADD;
        endcase
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clear_model();
        instret_m = 32'd0;
        mem_err_m = 1'b0;
        ill_m     = 1'b0;
    endtask

    task automatic drive(input exp_t e, input logic mr, input logic rn);
        @(posedge clk);
        #1;
        bus.mem_ready = mr;
        rst_n         = rn;
        sb.push_back(e);
    endtask

    // w: MEM cycles with mem_ready low before it rises; rst_at: MEM cycle index that gets a reset (-1 none)
    task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int w, input int rst_at);
        kind_t k;
        exp_t  e;
        logic  done;
        k = kind_of(op, f3, f7);
        e = mk(3'd0);
        e.pc_write = 1'b1;
        e.ir_write = 1'b1;
        drive(e, rnd1(), 1'b1);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        bus.alu_zero = z;
        drive(mk(3'd1), rnd1(), 1'b1);
        if (k == K_UNK) begin
`ifdef ILLEGAL_TRAP_EN
            ill_m = 1'b1;
            for (int i = 0; i < 20; i++) drive(mk(3'd5), rnd1(), 1'b1);
            drive(mk(3'd5), rnd1(), 1'b0);
            clear_model();
`else
            instret_m = instret_m + 32'd1;
`endif
            return;
        end
        e = mk(3'd2);
        e.alu_sel = alu_of(k);
        e.alu_src = (k inside {K_ADDI, K_ANDI, K_ORI, K_LW, K_SW});
        if (k == K_BEQ || k == K_BNE) begin
            e.branch   = 1'b1;
            e.pc_src   = 1'b1;
            e.pc_write = (k == K_BEQ) ? z : ~z;
        end
        drive(e, rnd1(), 1'b1);
        if (k == K_BEQ || k == K_BNE) begin
            instret_m = instret_m + 32'd1;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            done = 1'b0;
            for (int i = 0; i < TMO && !done; i++) begin
                e = mk(3'd3);
                if (i == rst_at) begin
                    drive(e, 1'b0, 1'b0);
                    clear_model();
                    return;
                end
                e.mem_read  = (k == K_LW);
                e.mem_write = (k == K_SW);
                done = (i == w);
                drive(e, done, 1'b1);
            end
            if (!done) begin
                mem_err_m = 1'b1;
                return;
            end
            if (k == K_SW) begin
                instret_m = instret_m + 32'd1;
                return;
            end
        end
        e = mk(3'd4);
        e.reg_write  = 1'b1;
        e.mem_to_reg = (k == K_LW);
        drive(e, rnd1(), 1'b1);
        instret_m = instret_m + 32'd1;
    endtask

    // Monitor: one comparison per cycle whenever an expectation is queued
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (sb.size() != 0) begin
            e            = sb.pop_front();
            a.st         = bus.state_o;
            a.pc_write   = bus.pc_write;
            a.pc_src     = bus.pc_src;
            a.ir_write   = bus.ir_write;
            a.alu_src    = bus.alu_src;
            a.alu_sel    = bus.alu_sel;
            a.mem_read   = bus.mem_read;
            a.mem_write  = bus.mem_write;
            a.mem_to_reg = bus.mem_to_reg;
            a.reg_write  = bus.reg_write;
            a.branch     = bus.branch;
            a.mem_err    = bus.mem_err;
            a.ill        = bus.illegal_insn;
            a.instret    = bus.instret;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle_vec %0d @%0t: got st=%0d ctrl=%h instret=%0d, want st=%0d ctrl=%h instret=%0d",
                         n_vec, $time, a.st, a[48:32], a.instret, e.st, e[48:32], e.instret);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int         w;
        rst_n        = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode   = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7_5 = 1'b0;
        bus.alu_zero = 1'b0;
        clear_model();
        drive(mk(3'd0), 1'b0, 1'b0);

        run_insn(7'b0110011, 3'b000, 1'b0, 1'b0, 0, -1);   // ADD
        run_insn(7'b0110011, 3'b000, 1'b1, 1'b0, 0, -1);   // SUB
        run_insn(7'b0000011, 3'b010, 1'b0, 1'b0, 3, -1);   // LW, 3 wait cycles
        run_insn(7'b0100011, 3'b010, 1'b0, 1'b0, 99, -1);  // SW timeout
        run_insn(7'b0100011, 3'b010, 1'b0, 1'b0, 14, -1);  // SW ready on last cycle
        run_insn(7'b1100011, 3'b000, 1'b0, 1'b1, 0, -1);   // BEQ taken
        run_insn(7'b1100011, 3'b001, 1'b0, 1'b1, 0, -1);   // BNE not taken
        run_insn(7'b0010011, 3'b111, 1'b1, 1'b0, 0, -1);   // ANDI
        run_insn(7'b1111111, 3'b000, 1'b0, 1'b0, 0, -1);   // unknown
        run_insn(7'b0000011, 3'b010, 1'b0, 1'b0, 5, 2);    // LW reset in MEM

        for (int n = 0; n < 70; n++) begin
            case ($urandom_range(0, 9))
                0: begin op = 7'b0110011; f3 = 3'b000; end
                1: begin op = 7'b0110011; f3 = $urandom_range(0, 1) ? 3'b111 : 3'b110; end
                2: begin op = 7'b0010011; f3 = 3'b000; end
                3: begin op = 7'b0010011; f3 = $urandom_range(0, 1) ? 3'b111 : 3'b110; end
                4, 5: begin op = 7'b0000011; f3 = 3'b010; end
                6: begin op = 7'b0100011; f3 = 3'b010; end
                7: begin op = 7'b1100011; f3 = 3'($urandom_range(0, 1)); end
                default: begin op = 7'($urandom); f3 = 3'($urandom); end
            endcase
            case ($urandom_range(0, 7))
                0:       w = 20;
                1:       w = 14;
                default: w = $urandom_range(0, 4);
            endcase
            run_insn(op, f3, rnd1(), rnd1(), w, ($urandom_range(0, 15) == 0) ? 1 : -1);
        end

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
